btn_event_arbiter: RTL and testbench
====================================

BTN_EVENT_ARBITER -- requirements
Module: btn_event_arbiter

Interface
REQ-001 Parameter N_BTN, default 4, number of debounced button sources (2..8).
REQ-002 Parameter CNT_W, default 2, width of each per-button pending counter; saturates at 2^CNT_W-1.
REQ-003 clk  input  1  system clock, 100 MHz; one clock domain only.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 btn_pulse  input  N_BTN  single-cycle press pulses from the debounce instances, bit i = button i, synchronous to clk.
REQ-006 evt_ready  input  1  consumer accepts the offered event this cycle.
REQ-007 evt_valid  output  1  an event is offered on evt_id.
REQ-008 evt_id  output  clog2(N_BTN)  index of the button whose press is offered.
REQ-009 clr_overrun  input  1  single-cycle clear of overrun_flags.
REQ-010 overrun_flags  output  N_BTN  sticky per-button flags: a press was lost to a saturated counter.

Function
REQ-011 Each button SHALL have a pending counter cnt[i] that increments on btn_pulse[i] and decrements when an event for i is loaded into the output register.
REQ-012 Pulse and load on the same button in the same cycle SHALL leave cnt[i] unchanged, with no overrun.
REQ-013 A pulse on a saturated cnt[i] without a simultaneous load SHALL leave cnt[i] at its maximum and set overrun_flags[i].
REQ-014 FSM states SHALL be IDLE (evt_valid=0) and OFFER (evt_valid=1).
REQ-015 IDLE: if any cnt[i]!=0, select a winner, load evt_id, decrement its counter, and go to OFFER.
REQ-016 OFFER with evt_ready=0: evt_valid and evt_id SHALL hold stable; no counter decrement.
REQ-017 OFFER with evt_ready=1 and any cnt!=0: load the next winner in the same cycle and stay in OFFER, giving one event per cycle with no bubble.
REQ-018 OFFER with evt_ready=1 and all cnt==0: go to IDLE and deassert evt_valid.
REQ-019 Winner selection SHALL be round-robin.
- Search starts at (last_grant+1) mod N_BTN.
- The first index with cnt!=0 wins.
- last_grant updates to the winner on every load.
REQ-020 Arbitration SHALL use registered counters only, so a pulse sampled at edge t produces evt_valid=1 at edge t+2 at the earliest.
REQ-021 clr_overrun SHALL clear all overrun_flags, but a flag set in the same cycle SHALL take priority and remain set.
REQ-022 The index increment SHALL wrap modulo N_BTN for non-power-of-two N_BTN; evt_id SHALL never exceed N_BTN-1.
REQ-023 evt_ready while evt_valid=0 SHALL be ignored.

Reset
REQ-024 rst_n low SHALL asynchronously force the following values, discarding all pending presses and any in-flight offer:
- state=IDLE
- cnt[]=0
- evt_valid=0
- evt_id=0
- last_grant=N_BTN-1, so the first search starts at index 0
- overrun_flags=0
REQ-025 After rst_n deasserts, the first btn_pulse SHALL be accepted on the first rising edge.

Structure
REQ-026 The FSM state encodings (IDLE, OFFER) and the N_BTN/CNT_W defaults SHALL live in a shared constants header used by this block and its bench.
REQ-027 Round-robin selection SHALL be a separate combinational sub-module, rr_pick, with:
- inputs: request vector and last_grant;
- outputs: grant index and any-request flag.

Verification
REQ-028 Single press: pulse on btn 2 with evt_ready=1 -> evt_valid=1, evt_id=2 two cycles later for exactly one cycle, then IDLE.
REQ-029 Fairness: pulses on btns 0,1,3 in the same cycle after reset, evt_ready=1 -> evt_id sequence 0,1,3 on consecutive cycles, evt_valid continuous for 3 cycles.
REQ-030 Backpressure: evt_ready=0 for 10 cycles while offering id 1 -> evt_id stays 1 and evt_valid stays 1; 3 further pulses on btn 1 -> cnt[1]=3 and no overrun; a 4th pulse -> overrun_flags[1]=1.
REQ-031 Saturation boundary: cnt[0]=3, pulse on btn 0 in the same cycle as a load of btn 0 -> cnt[0] stays 3 and overrun_flags[0] stays 0.
REQ-032 Clear collision: clr_overrun and a new overrun on btn 3 in the same cycle -> overrun_flags=4'b1000.
REQ-033 Reset mid-operation: assert rst_n=0 during OFFER with cnt[2]=2 -> evt_valid=0 immediately; after release, no events appear without new pulses.

Source files
------------

// File: rtl/btn_event_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter_pkg
// Shared constants for the button event arbiter and its bench:
//   - state_t   : arbiter FSM encoding (IDLE = nothing offered, OFFER = event
//                 presented on evt_id with evt_valid high)
//   - N_BTN_DEF : default number of button sources
//   - CNT_W_DEF : default width of each per-button pending counter
// -----------------------------------------------------------------------------
package btn_event_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int N_BTN_DEF = 4;
    localparam int CNT_W_DEF = 2;

endpackage : btn_event_arbiter_pkg

// File: rtl/btn_event_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. The search starts one index after
// last_grant and wraps modulo N, so non-power-of-two N never yields an
// index >= N.
// Ports:
//   req        in  N     request vector (bit i = source i has work)
//   last_grant in  ID_W  index granted most recently
//   grant      out ID_W  first requesting index after last_grant (0 if none)
//   any_req    out 1     at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last_grant,
    output logic [ID_W-1:0] grant,
    output logic            any_req
);

    always_comb begin
        int  idx;
        logic found;
        grant   = '0;
        any_req = |req;
        found   = 1'b0;
        idx     = 0;
        // k runs 1..N so last_grant itself is visited last.
        for (int k = 1; k <= N; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

endmodule : rr_pick

// File: rtl/btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// btn_event_arbiter
// Collects single-cycle press pulses from N_BTN debounced buttons into
// per-button saturating pending counters and offers them one at a time to a
// consumer, choosing among pending buttons in round-robin order.
//
// Handshake: an event transfers on a clock edge where evt_valid and evt_ready
// are both high. While evt_valid is high and evt_ready is low, evt_valid and
// evt_id hold stable. evt_ready is ignored while evt_valid is low.
//
// Ports:
//   clk           in  1            system clock
//   rst_n         in  1            asynchronous active-low reset
//   btn_pulse     in  N_BTN        press pulses, bit i = button i
//   evt_ready     in  1            consumer accepts the offered event
//   evt_valid     out 1            an event is offered on evt_id
//   evt_id        out clog2(N_BTN) button index of the offered event
//   clr_overrun   in  1            clears overrun_flags (a same-cycle set wins)
//   overrun_flags out N_BTN        sticky: a press was lost to a full counter
//   state_dbg     out state_t      current FSM state
//   cnt_dbg       out N_BTN*CNT_W  pending counters, button i at [i*CNT_W +: CNT_W]
// -----------------------------------------------------------------------------
module btn_event_arbiter
    import btn_event_arbiter_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int ID_W  = $clog2(N_BTN)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_BTN-1:0]       btn_pulse,
    input  logic                   evt_ready,
    output logic                   evt_valid,
    output logic [ID_W-1:0]        evt_id,
    input  logic                   clr_overrun,
    output logic [N_BTN-1:0]       overrun_flags,
    output state_t                 state_dbg,
    output logic [N_BTN*CNT_W-1:0] cnt_dbg
);

    localparam logic [CNT_W-1:0] CNT_MAX       = '1;
    localparam logic [ID_W-1:0]  LAST_GRANT_RST = ID_W'(N_BTN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q [N_BTN];
    logic [CNT_W-1:0]   cnt_d [N_BTN];
    logic [ID_W-1:0]    evt_id_q;
    logic [ID_W-1:0]    last_grant_q;
    logic [N_BTN-1:0]   ovr_q, ovr_d, ovr_set;
    logic [N_BTN-1:0]   req;
    logic [ID_W-1:0]    grant;
    logic               any_req;
    logic               load;

    // Requests come from registered counters only, so a fresh pulse needs
    // one edge to reach its counter before it can be arbitrated.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            req[i] = (cnt_q[i] != '0);
        end
    end

    rr_pick #(
        .N    (N_BTN),
        .ID_W (ID_W)
    ) u_rr_pick (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_req    (any_req)
    );

    // FSM next state and load decision.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    load    = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    // Back-to-back reload keeps evt_valid high with no bubble.
                    if (any_req) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending counters. A pulse and a load on the same button cancel, which
    // also means a full counter being loaded can absorb a pulse without loss.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            logic dec;
            cnt_d[i]   = cnt_q[i];
            ovr_set[i] = 1'b0;
            dec        = load && (grant == ID_W'(i));
            if (btn_pulse[i] && !dec) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovr_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (dec && !btn_pulse[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
        // A flag set this cycle survives a simultaneous clear.
        ovr_d = (clr_overrun ? '0 : ovr_q) | ovr_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            evt_id_q     <= '0;
            last_grant_q <= LAST_GRANT_RST;
            ovr_q        <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            ovr_q   <= ovr_d;
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            if (load) begin
                evt_id_q     <= grant;
                last_grant_q <= grant;
            end
        end
    end

    assign evt_valid     = (state_q == OFFER);
    assign evt_id        = evt_id_q;
    assign overrun_flags = ovr_q;
    assign state_dbg     = state_q;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            cnt_dbg[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

endmodule : btn_event_arbiter

// File: tb/tb_btn_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_btn_event_arbiter
// Directed bench for btn_event_arbiter with default parameters (4 buttons,
// 2-bit counters). Inputs change 1 ns after a rising edge; outputs are
// compared at that same point, i.e. they reflect the edge just taken.
// -----------------------------------------------------------------------------
module tb_btn_event_arbiter;
    import btn_event_arbiter_pkg::*;

    localparam int N = N_BTN_DEF;
    localparam int W = CNT_W_DEF;

    // ---------------- clock / reset ----------------
    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   btn_pulse = '0;
    logic           evt_ready = 1'b0;
    logic           clr_overrun = 1'b0;
    logic           evt_valid;
    logic [1:0]     evt_id;
    logic [N-1:0]   overrun_flags;
    state_t         state_dbg;
    logic [N*W-1:0] cnt_dbg;

    always #5 clk = ~clk;

    btn_event_arbiter #(
        .N_BTN (N),
        .CNT_W (W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_pulse     (btn_pulse),
        .evt_ready     (evt_ready),
        .evt_valid     (evt_valid),
        .evt_id        (evt_id),
        .clr_overrun   (clr_overrun),
        .overrun_flags (overrun_flags),
        .state_dbg     (state_dbg),
        .cnt_dbg       (cnt_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    function automatic logic [W-1:0] cnt_of(input int i);
        return cnt_dbg[i*W +: W];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] p, input logic rdy, input logic clr);
        btn_pulse   = p;
        evt_ready   = rdy;
        clr_overrun = clr;
    endtask

    // Reset, then release at a falling edge so the next rising edge is the
    // first one that samples inputs.
    task automatic do_reset();
        drive('0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Apply a pulse pattern for one edge, then return inputs to idle pulses.
    task automatic pulse_cycle(input logic [N-1:0] p, input logic rdy);
        drive(p, rdy, 1'b0);
        tick();
        drive('0, rdy, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] pulse;
        logic         rdy;
        logic         clr;
        logic         exp_valid;
        logic [1:0]   exp_id;
        logic [N-1:0] exp_ovr;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Fairness after reset: 0,1,3 back-to-back; single press on 2;
        // round-robin wrap 0 then 2; pulse coinciding with its own load.
        //            pulse    rdy   clr   valid id     ovr
        vecs[0]  = '{4'b1011, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000};
        vecs[2]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000};
        vecs[3]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd3, 4'b0000};
        vecs[4]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[5]  = '{4'b0100, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[6]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000};
        vecs[7]  = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[8]  = '{4'b0101, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[9]  = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000};
        vecs[10] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd2, 4'b0000};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[12] = '{4'b0010, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};
        vecs[13] = '{4'b0010, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000};
        vecs[14] = '{4'b0000, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0000};
        vecs[15] = '{4'b0000, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000};

        // ---------- reset values ----------
        do_reset();
        check("rst_valid", 32'(evt_valid), 32'd0);
        check("rst_id", 32'(evt_id), 32'd0);
        check("rst_ovr", 32'(overrun_flags), 32'd0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        check("rst_cnt", 32'(cnt_dbg), 32'd0);

        // ---------- table run (first pulse lands on first edge after release) ----------
        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].pulse, vecs[v].rdy, vecs[v].clr);
            tick();
            check($sformatf("vec%0d_valid", v), 32'(evt_valid), 32'(vecs[v].exp_valid));
            if (vecs[v].exp_valid) begin
                check($sformatf("vec%0d_id", v), 32'(evt_id), 32'(vecs[v].exp_id));
            end
            check($sformatf("vec%0d_ovr", v), 32'(overrun_flags), 32'(vecs[v].exp_ovr));
        end
        drive('0, 1'b0, 1'b0);

        // ---------- backpressure on id 1, then saturation of cnt[1] ----------
        do_reset();
        pulse_cycle(4'b0010, 1'b0);
        tick();
        check("bp_start_valid", 32'(evt_valid), 32'd1);
        check("bp_start_id", 32'(evt_id), 32'd1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("bp_hold%0d_valid", c), 32'(evt_valid), 32'd1);
            check($sformatf("bp_hold%0d_id", c), 32'(evt_id), 32'd1);
        end
        for (int c = 0; c < 3; c++) begin
            pulse_cycle(4'b0010, 1'b0);
        end
        check("bp_cnt1_full", 32'(cnt_of(1)), 32'd3);
        check("bp_no_ovr", 32'(overrun_flags), 32'd0);
        check("bp_id_still1", 32'(evt_id), 32'd1);
        pulse_cycle(4'b0010, 1'b0);
        check("bp_ovr1", 32'(overrun_flags), 32'b0010);
        check("bp_cnt1_sat", 32'(cnt_of(1)), 32'd3);

        // ---------- pulse on full cnt[0] while cnt[0] is being loaded ----------
        do_reset();
        pulse_cycle(4'b0001, 1'b0);
        tick();
        for (int c = 0; c < 3; c++) begin
            pulse_cycle(4'b0001, 1'b0);
        end
        check("sat_cnt0_full", 32'(cnt_of(0)), 32'd3);
        drive(4'b0001, 1'b1, 1'b0);
        tick();
        drive('0, 1'b0, 1'b0);
        check("sat_cnt0_kept", 32'(cnt_of(0)), 32'd3);
        check("sat_no_ovr", 32'(overrun_flags), 32'd0);
        check("sat_valid", 32'(evt_valid), 32'd1);
        check("sat_id", 32'(evt_id), 32'd0);

        // ---------- clear colliding with a new overrun on btn 3 ----------
        do_reset();
        pulse_cycle(4'b0001, 1'b0);
        tick();
        for (int c = 0; c < 4; c++) begin
            pulse_cycle(4'b0001, 1'b0);
        end
        check("clr_pre_ovr0", 32'(overrun_flags), 32'b0001);
        for (int c = 0; c < 3; c++) begin
            pulse_cycle(4'b1000, 1'b0);
        end
        check("clr_pre_cnt3", 32'(cnt_of(3)), 32'd3);
        drive(4'b1000, 1'b0, 1'b1);
        tick();
        check("clr_collide", 32'(overrun_flags), 32'b1000);
        drive('0, 1'b0, 1'b1);
        tick();
        drive('0, 1'b0, 1'b0);
        check("clr_plain", 32'(overrun_flags), 32'b0000);

        // ---------- asynchronous reset during OFFER with cnt[2]=2 ----------
        do_reset();
        pulse_cycle(4'b0100, 1'b0);
        tick();
        pulse_cycle(4'b0100, 1'b0);
        pulse_cycle(4'b0100, 1'b0);
        check("arst_pre_cnt2", 32'(cnt_of(2)), 32'd2);
        check("arst_pre_valid", 32'(evt_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid_now", 32'(evt_valid), 32'd0);
        check("arst_cnt_now", 32'(cnt_dbg), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check($sformatf("arst_quiet%0d", c), 32'(evt_valid), 32'd0);
        end
        evt_ready = 1'b0;

        // ---------- final report ----------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_btn_event_arbiter
